// File: rtl/multicycle_control.sv
// Multi-cycle instruction control sequencer.
// Steps one decoded RISC-V instruction through DECODE / EXECUTE / MEM / WB,
// drives register write-back and data-memory strobes, and holds them across
// a req/ack handshake. Raises one-cycle traps for illegal opcodes, memory
// timeouts and (optionally) misaligned accesses.
// Optional feature macro: CTRL_MISALIGN_TRAP_EN -- when defined, misaligned
// loads/stores trap with cause 1 instead of being issued.
module multicycle_control #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15,
    localparam int BE     = XLEN / 8,
    localparam int LSB_W  = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [LSB_W-1:0] addr_lsb,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             load_enable,
    output logic             store_enable,
    output logic [BE-1:0]    mem_write_enable,
    output logic             reg_write,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_TRAP    = 3'd5;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

    // Last MEM cycle index that may still complete before the timeout trap.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    cause_q, cause_d;
    logic [7:0]    cnt_q;
    logic [6:0]    opcode_p0;
    logic [2:0]    func3_p0;
    logic [BE-1:0] mask_p1;
    logic          cls_wb, cls_ld, cls_st;

    function automatic logic is_wb_op(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Byte, half, word always legal; double only on a 64-bit datapath.
    function automatic logic store_f3_ok(input logic [2:0] f3);
        if (f3[2])
            return 1'b0;
        if (f3[1:0] == 2'b11)
            return (XLEN == 64);
        return 1'b1;
    endfunction

    // Lane mask for the access size, shifted to the byte offset; lanes past BE drop off.
    function automatic logic [BE-1:0] store_mask(input logic [1:0] size,
                                                 input logic [LSB_W-1:0] lsb);
        logic [15:0] m;
        case (size)
            2'b00:   m = 16'h0001;
            2'b01:   m = 16'h0003;
            2'b10:   m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        m = m << lsb;
        return m[BE-1:0];
    endfunction

`ifdef CTRL_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [LSB_W-1:0] lsb);
        logic [2:0] low_bits;
        case (size)
            2'b00:   low_bits = 3'b000;
            2'b01:   low_bits = 3'b001;
            2'b10:   low_bits = 3'b011;
            default: low_bits = 3'b111;
        endcase
        return (3'(lsb) & low_bits) != 3'b000;
    endfunction
`endif

    assign cls_wb = is_wb_op(opcode_p0);
    assign cls_ld = (opcode_p0 == 7'b0000011);
    assign cls_st = (opcode_p0 == 7'b0100011);

    // Next-state and trap-cause selection.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!(cls_wb || cls_ld || cls_st) || (cls_st && !store_f3_ok(func3_p0))) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (cls_wb) begin
                    state_d = S_WB;
`ifdef CTRL_MISALIGN_TRAP_EN
                end else if (misaligned(func3_p0[1:0], addr_lsb)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_MISALIGN;
`endif
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                // An ack arriving on the timeout cycle still completes the access.
                if (mem_ack) begin
                    state_d = cls_ld ? S_WB : S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_TRAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: FSM, MEM wait counter and sticky trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cause_q <= CAUSE_ILLEGAL;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= (state_q == S_MEM) ? cnt_q + 8'd1 : 8'd0;
        end
    end

    // Instruction fields captured at accept, byte mask captured in EXECUTE.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && instr_valid) begin
            opcode_p0 <= opcode;
            func3_p0  <= func3;
        end
        if (state_q == S_EXECUTE)
            mask_p1 <= store_mask(func3_p0[1:0], addr_lsb);
    end

    assign instr_ready      = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign mem_req          = (state_q == S_MEM);
    assign load_enable      = mem_req && cls_ld;
    assign store_enable     = mem_req && cls_st;
    assign mem_write_enable = store_enable ? mask_p1 : '0;
    assign reg_write        = (state_q == S_WB);
    assign trap             = (state_q == S_TRAP);
    assign trap_cause       = cause_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle instruction control sequencer for the RV32/RV64 datapath; the registered successor to the single-cycle combinational decoder. It accepts one decoded instruction at a time and steps it through DECODE/EXECUTE/MEM/WB. It drives register write-back, load/store strobes and per-byte write enables, and holds them through a req/ack memory handshake. It sits between the fetch stage and the register file / data-memory port, and flags illegal opcodes and memory timeouts.

## Interface
- XLEN, 32: datapath width, 32 or 64; byte-enable width BE = XLEN/8.
- TIMEOUT, 15: maximum cycles in MEM without `mem_ack` before trapping (1..255).

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- opcode  in  7  RISC-V opcode, sampled at accept.
- func3  in  3  funct3, sampled at accept.
- addr_lsb  in  log2(BE)  effective-address low bits, sampled in EXECUTE.
- mem_ack  in  1  data memory completes the current access.
- mem_req  out  1  memory access request, held until ack.
- load_enable  out  1  read strobe, valid with mem_req.
- store_enable  out  1  write strobe, valid with mem_req.
- mem_write_enable  out  BE  byte lanes to write, valid with store_enable.
- reg_write  out  1  one-cycle register-file write pulse.
- trap  out  1  one-cycle trap pulse.
- trap_cause  out  2  0 illegal opcode, 1 misaligned, 2 memory timeout; held until next trap.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, DECODE, EXECUTE, MEM, WB, TRAP.
- IDLE: `instr_ready`=1. On `instr_valid`, latch `opcode`/`func3` and go to DECODE.
- DECODE: classify the opcode.
  - Write-back class: 0110011, 0010011, 0110111, 0010111, 1101111, 1100111.
  - Load class: 0000011.
  - Store class: 0100011.
  - Any other opcode → TRAP with cause 0. Otherwise → EXECUTE.
- EXECUTE: sample `addr_lsb`. Write-back class → WB; load/store class → MEM.
- Store byte mask by func3:
  - 000 → 1 lane.
  - 001 → 2 lanes.
  - 010 → 4 lanes.
  - 011 → 8 lanes, only when XLEN=64.
  - Any other func3 → TRAP cause 0.
  - The mask is shifted left by `addr_lsb` and truncated to BE bits.
- MEM:
  - Assert `mem_req` plus `load_enable` or `store_enable`/`mem_write_enable`; all are stable until ack.
  - On `mem_ack`: load → WB, store → IDLE.
  - A cycle counter starts at 0 on MEM entry. If it reaches TIMEOUT with no ack → TRAP cause 2.
  - `mem_ack` in the same cycle as the timeout: the ack wins.
- WB: `reg_write`=1 for exactly one cycle, then IDLE.
- TRAP: `trap`=1 for one cycle; `trap_cause` updates on TRAP entry; then IDLE.
- `mem_ack` outside MEM is ignored. `instr_valid` outside IDLE is ignored and not buffered.

## Timing
- Accept at edge 0.
  - Write-back instruction: DECODE at cycle 1, EXECUTE at 2, `reg_write` at 3, `instr_ready` again at 4.
  - Store with ack on its first MEM cycle: MEM at cycle 3, IDLE at 4.
  - Load with ack on its first MEM cycle: MEM at cycle 3, WB (`reg_write`) at 4, IDLE at 5.
- All outputs are registered-state decodes; no input-to-output combinational path except none. `mem_write_enable` comes from the registered mask.
- Reset (asynchronous, any state, including mid-MEM): state goes to IDLE.
  - `instr_ready`=1.
  - `busy`, `mem_req`, `load_enable`, `store_enable`, `reg_write`, `trap` = 0.
  - `mem_write_enable`=0 and `trap_cause`=0.
  - An outstanding memory access is abandoned.

## Configuration
- `CTRL_MISALIGN_TRAP_EN` defined: a load/store whose `addr_lsb` is not aligned to its access size goes from EXECUTE to TRAP with cause 1. No `mem_req` is issued.
- Not defined: misaligned accesses are issued with the shifted, truncated mask (lanes past BE are dropped). Cause 1 is never produced.

## Test plan
- XLEN=32, opcode 0110011 accepted → `reg_write` high exactly at cycle 3; `instr_ready` high at cycle 4.
- Store func3=001, addr_lsb=2, ack after 3 MEM cycles → `mem_write_enable`=4'b1100 held for all 3 cycles; no `reg_write`.
- Load, `mem_ack` never asserted, TIMEOUT=15 → TRAP after 15 MEM cycles, `trap_cause`=2, `mem_req` drops.
- Opcode 1111111 → `trap` at cycle 2 with `trap_cause`=0; no memory strobes.
- Store func3=010, addr_lsb=1:
  - With `CTRL_MISALIGN_TRAP_EN` → `trap_cause`=1, no `mem_req`.
  - Without it → `mem_write_enable`=4'b1110.
- `rst_n` pulsed low during MEM → all outputs at reset values immediately, `instr_ready`=1 after release.
